key_event_module: RTL and testbench

//  Consumes the clean, debounced key level produced by the debounce stage and

---
 rtl/key_event_module.sv | 106 ++++++++++
 tb/tb_key_event_module.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_module.sv
// Turns a debounced active-low key level into one-cycle click / long-press / auto-repeat events.
// Latency: events are registered, visible the cycle after the deciding edge; no backpressure (pulses are fire-and-forget).
module key_event_module #(
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Key_In,
    output logic Click_Sig,
    output logic Long_Sig,
    output logic Repeat_Sig,
    output logic Hold_Level,
    output logic Step_Sig
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_q;
    logic               click_q, click_d;
    logic               long_q, long_d;
    logic               repeat_q, repeat_d;
    logic               fall;

    // key_q resets high so a key already held through reset reads as a fresh press.
    assign fall = key_q & ~Key_In;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        click_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                // Release is checked first so it beats the long threshold on the same edge.
                if (Key_In) begin
                    click_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (Key_In) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            key_q    <= 1'b1;
            click_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= Key_In;
            click_q  <= click_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign Click_Sig  = click_q;
    assign Long_Sig   = long_q;
    assign Repeat_Sig = repeat_q;
    assign Hold_Level = (state_q == HOLD);
    assign Step_Sig   = click_q | long_q | repeat_q;

endmodule

// File: tb/tb_key_event_module.sv
// Bench for key_event_module with LONG_CNT=8, REPEAT_CNT=4 against an elapsed-time reference model.
module tb_key_event_module;

    localparam int LONG = 8;
    localparam int REP  = 4;

    logic CLK = 1'b0;
    logic RSTn;
    logic Key_In;
    logic Click_Sig, Long_Sig, Repeat_Sig, Hold_Level, Step_Sig;

    int checks   = 0;
    int failures = 0;

    key_event_module #(
        .CNT_W      (8),
        .LONG_CNT   (LONG),
        .REPEAT_CNT (REP)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Key_In     (Key_In),
        .Click_Sig  (Click_Sig),
        .Long_Sig   (Long_Sig),
        .Repeat_Sig (Repeat_Sig),
        .Hold_Level (Hold_Level),
        .Step_Sig   (Step_Sig)
    );

    always #5 CLK = ~CLK;

    // Reference model: tracks edges elapsed since the press was first sampled and
    // derives events from the timing rules (long at +LONG, repeats every REP after).
    logic m_active, m_prev;
    int   m_n;
    logic e_click, e_long, e_rep, e_hold;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_active <= 1'b0;
            m_prev   <= 1'b1;
            m_n      <= 0;
            e_click  <= 1'b0;
            e_long   <= 1'b0;
            e_rep    <= 1'b0;
            e_hold   <= 1'b0;
        end else begin
            e_click <= 1'b0;
            e_long  <= 1'b0;
            e_rep   <= 1'b0;
            m_prev  <= Key_In;
            if (!m_active) begin
                e_hold <= 1'b0;
                if (m_prev && !Key_In) begin
                    m_active <= 1'b1;
                    m_n      <= 0;
                end
            end else if (Key_In) begin
                m_active <= 1'b0;
                e_click  <= ((m_n + 1) <= LONG);
                e_hold   <= 1'b0;
            end else begin
                m_n    <= m_n + 1;
                e_long <= ((m_n + 1) == LONG);
                e_rep  <= ((m_n + 1) > LONG) && (((m_n + 1 - LONG) % REP) == 0);
                e_hold <= ((m_n + 1) >= LONG);
            end
        end
    end

    wire [4:0] dut_v = {Click_Sig, Long_Sig, Repeat_Sig, Hold_Level, Step_Sig};
    wire [4:0] mod_v = {e_click, e_long, e_rep, e_hold, e_click | e_long | e_rep};

    // Drive the key for one clock; returns just after the following falling edge.
    task automatic tick(input logic k);
        Key_In = k;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RSTn   = 1'b0;
        Key_In = 1'b1;
        #1;
        checks++;
        if (dut_v !== 5'b0) begin
            failures++;
            $display("FAIL reset_immediate dut=%b expected=%b", dut_v, 5'b0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(i[0]);
            checks++;
            if (dut_v !== 5'b0) begin
                failures++;
                $display("FAIL reset_toggle cyc=%0d dut=%b expected=%b", i, dut_v, 5'b0);
            end
        end
        Key_In = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (dut_v !== 5'b0 || dut_v !== mod_v) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d dut=%b expected=%b", i, dut_v, mod_v);
            end
        end
    endtask

    task automatic test_click;
        int n_click = 0, n_other = 0;
        for (int i = 0; i < 12; i++) begin
            tick(i < 5 ? 1'b0 : 1'b1);
            n_click += Click_Sig;
            n_other += Long_Sig + Repeat_Sig;
            checks++;
            if (dut_v !== mod_v) begin
                failures++;
                $display("FAIL click cyc=%0d dut=%b model=%b", i, dut_v, mod_v);
            end
        end
        checks++;
        if (n_click != 1 || n_other != 0) begin
            failures++;
            $display("FAIL click_count clicks=%0d other=%0d expected 1/0", n_click, n_other);
        end
    endtask

    task automatic test_long_repeat;
        int long_at = -1, rep_first = -1, rep_last = -1;
        int n_rep = 0, n_step = 0, n_click = 0;
        for (int i = 0; i < 36; i++) begin
            tick(i < 30 ? 1'b0 : 1'b1);
            if (Long_Sig) long_at = i;
            if (Repeat_Sig) begin
                if (rep_first < 0) rep_first = i;
                rep_last = i;
                n_rep++;
            end
            n_step  += Step_Sig;
            n_click += Click_Sig;
            checks++;
            if (dut_v !== mod_v) begin
                failures++;
                $display("FAIL long_repeat cyc=%0d dut=%b model=%b", i, dut_v, mod_v);
            end
        end
        checks++;
        if (long_at != 8 || rep_first != 12 || rep_last != 28 || n_rep != 5) begin
            failures++;
            $display("FAIL long_timing long=%0d rep=%0d..%0d n=%0d expected 8 12..28 5",
                     long_at, rep_first, rep_last, n_rep);
        end
        checks++;
        if (n_step != 6 || n_click != 0) begin
            failures++;
            $display("FAIL long_steps steps=%0d clicks=%0d expected 6/0", n_step, n_click);
        end
    endtask

    task automatic test_release_at_long;
        int n_click = 0, n_long = 0;
        for (int i = 0; i < 14; i++) begin
            tick(i < 8 ? 1'b0 : 1'b1);
            n_click += Click_Sig;
            n_long  += Long_Sig;
            checks++;
            if (dut_v !== mod_v) begin
                failures++;
                $display("FAIL release_at_long cyc=%0d dut=%b model=%b", i, dut_v, mod_v);
            end
        end
        checks++;
        if (n_click != 1 || n_long != 0) begin
            failures++;
            $display("FAIL release_at_long_count clicks=%0d longs=%0d expected 1/0", n_click, n_long);
        end
    endtask

    task automatic test_reset_mid_hold;
        int long_at = -1;
        for (int i = 0; i < 14; i++) tick(1'b0);
        #2 RSTn = 1'b0;
        #1;
        checks++;
        if (dut_v !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_hold dut=%b expected=%b", dut_v, 5'b0);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            if (Long_Sig && long_at < 0) long_at = i;
            checks++;
            if (dut_v !== mod_v) begin
                failures++;
                $display("FAIL reset_reentry cyc=%0d dut=%b model=%b", i, dut_v, mod_v);
            end
        end
        checks++;
        if (long_at != 8) begin
            failures++;
            $display("FAIL reset_reentry_long long_at=%0d expected 8", long_at);
        end
        for (int i = 0; i < 4; i++) tick(1'b1);
    endtask

    task automatic test_glitch_and_idle;
        int n_click = 0, n_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            tick(i == 2 ? 1'b0 : 1'b1);
            n_click += Click_Sig;
        end
        checks++;
        if (n_click != 1) begin
            failures++;
            $display("FAIL glitch_click clicks=%0d expected 1", n_click);
        end
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            n_pulse += Step_Sig + Hold_Level;
        end
        checks++;
        if (n_pulse != 0) begin
            failures++;
            $display("FAIL idle_quiet pulses=%0d expected 0", n_pulse);
        end
    endtask

    task automatic test_random;
        logic k = 1'b1;
        int   run = 0;
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                k   = ~k;
                run = k ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 40));
            end
            run--;
            tick(k);
            checks++;
            if (dut_v !== mod_v) begin
                failures++;
                $display("FAIL random cyc=%0d dut=%b model=%b", i, dut_v, mod_v);
            end
            checks++;
            if ((Click_Sig + Long_Sig + Repeat_Sig) > 1) begin
                failures++;
                $display("FAIL onehot cyc=%0d c=%b l=%b r=%b expected at most one",
                         i, Click_Sig, Long_Sig, Repeat_Sig);
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1);
    endtask

    initial begin
        RSTn   = 1'b0;
        Key_In = 1'b1;
        test_reset();
        test_click();
        test_long_repeat();
        test_release_at_long();
        test_reset_mid_hold();
        test_glitch_and_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
